hilo_ctrl: RTL and testbench

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl.sv | 107 ++++++++++
 tb/tb_hilo_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register file with a sequencer for a multi-cycle external multiplier.
module hilo_ctrl #(
    parameter int MULT_LAT = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_mult,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] prod_hi,
    input  logic [31:0] prod_lo,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic        mult_init,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [5:0] LAST    = 6'(MULT_LAT - 1);

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d, hi_q, hi_d, lo_q, lo_d;
    logic        mult_init_q, mult_init_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mult_a_d    = mult_a_q;
        mult_b_d    = mult_b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mult_init_d = mult_init_q;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            IDLE: begin
                if (op_mult) begin
                    mult_a_d    = rs_val;
                    mult_b_d    = rt_val;
                    cnt_d       = 6'd0;
                    mult_init_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end else begin
                    hi_d = op_mthi ? rs_val : hi_q;
                    lo_d = op_mtlo ? rs_val : lo_q;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    hi_d        = prod_hi;
                    lo_d        = prod_lo;
                    mult_init_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = CAPTURE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            CAPTURE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            mult_a_q    <= 32'd0;
            mult_b_q    <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            mult_init_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mult_a_q    <= mult_a_d;
            mult_b_q    <= mult_b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mult_init_q <= mult_init_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;
    assign mult_init = mult_init_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed tests for hilo_ctrl with a signed multiplier model.
module tb_hilo_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        op_mult, op_mthi, op_mtlo;
    logic [31:0] rs_val, rt_val, prod_hi, prod_lo;
    logic [31:0] mult_a, mult_b, hi, lo;
    logic        mult_init, busy, done;
    logic signed [63:0] prod;
    int checks = 0;
    int errors = 0;

    hilo_ctrl #(.MULT_LAT(34)) dut (
        .clk(clk), .reset(reset), .op_mult(op_mult), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
        .rs_val(rs_val), .rt_val(rt_val), .prod_hi(prod_hi), .prod_lo(prod_lo),
        .mult_a(mult_a), .mult_b(mult_b), .mult_init(mult_init), .hi(hi), .lo(lo),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign prod = $signed(mult_a) * $signed(mult_b);
    assign prod_hi = prod[63:32];
    assign prod_lo = prod[31:0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = done;
        end
    endtask

    task automatic test_reset();
        op_mthi = 1'b1; op_mtlo = 1'b1; rs_val = 32'hA5A5_0001;
        step();
        op_mthi = 1'b0; op_mtlo = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
        checks++; if (mult_a !== 32'd0) begin errors++; $display("FAIL reset_mult_a got %h want 0", mult_a); end
        checks++; if (mult_b !== 32'd0) begin errors++; $display("FAIL reset_mult_b got %h want 0", mult_b); end
        checks++; if ({mult_init, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {mult_init, busy, done}); end
        step();
        reset = 1'b0;
    endtask

    task automatic test_mult();
        int n_init = 0, n_done = 0, done_at = -1, busy_last = -1;
        op_mult = 1'b1; rs_val = 32'd7; rt_val = 32'hFFFF_FFFD;
        step();
        op_mult = 1'b0;
        checks++; if ({mult_init, busy} !== 2'b11) begin errors++; $display("FAIL mult_start got %b want 11", {mult_init, busy}); end
        checks++; if (mult_a !== 32'd7 || mult_b !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mult_ops got %h %h want 7 fffffffd", mult_a, mult_b); end
        if (mult_init) n_init++;
        for (int e = 1; e <= 36; e++) begin
            step();
            if (mult_init) n_init++;
            if (done) begin n_done++; done_at = e; end
            if (busy) busy_last = e;
        end
        checks++; if (n_init != 34) begin errors++; $display("FAIL mult_init_cycles got %0d want 34", n_init); end
        checks++; if (done_at != 34 || n_done != 1) begin errors++; $display("FAIL mult_done got edge %0d count %0d want 34 1", done_at, n_done); end
        checks++; if (busy_last != 34) begin errors++; $display("FAIL mult_busy_last got %0d want 34", busy_last); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
    endtask

    task automatic test_moves();
        op_mthi = 1'b1; op_mtlo = 1'b1; rs_val = 32'h1234_5678;
        step();
        op_mthi = 1'b0; op_mtlo = 1'b0;
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL move_hi got %h want 12345678", hi); end
        checks++; if (lo !== 32'h1234_5678) begin errors++; $display("FAIL move_lo got %h want 12345678", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL move_busy got %b want 0", busy); end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        op_mult = 1'b1; rs_val = 32'd3; rt_val = 32'd5;
        step();
        op_mult = 1'b0;
        repeat (5) step();
        op_mthi = 1'b1; op_mult = 1'b1; rs_val = 32'h0000_DEAD; rt_val = 32'd99;
        repeat (3) step();
        op_mthi = 1'b0; op_mult = 1'b0;
        checks++; if (mult_a !== 32'd3 || mult_b !== 32'd5) begin errors++; $display("FAIL busy_ops got %h %h want 3 5", mult_a, mult_b); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL busy_hi_held got %h want 12345678", hi); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_done_timeout got 0 want 1"); end
        checks++; if (hi !== 32'd0 || lo !== 32'd15) begin errors++; $display("FAIL busy_result got %h %h want 0 f", hi, lo); end
        step();
        checks++; if (busy !== 1'b0 || mult_a !== 32'd3) begin errors++; $display("FAIL busy_end got busy %b a %h want 0 3", busy, mult_a); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        op_mult = 1'b1; op_mtlo = 1'b1; rs_val = 32'd2; rt_val = 32'd4;
        step();
        op_mult = 1'b0; op_mtlo = 1'b0;
        checks++; if (busy !== 1'b1 || mult_a !== 32'd2) begin errors++; $display("FAIL sim_start got busy %b a %h want 1 2", busy, mult_a); end
        checks++; if (lo !== 32'd15) begin errors++; $display("FAIL sim_lo_held got %h want f", lo); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sim_done_timeout got 0 want 1"); end
        checks++; if (hi !== 32'd0 || lo !== 32'd8) begin errors++; $display("FAIL sim_result got %h %h want 0 8", hi, lo); end
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n_done = 0;
        reset = 1'b1; step(); reset = 1'b0;
        op_mult = 1'b1; rs_val = 32'd6; rt_val = 32'd7;
        step();
        op_mult = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        #1;
        checks++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset got %h %h %b want 0 0 0", hi, lo, busy); end
        step();
        reset = 1'b0;
        for (int e = 0; e < 40; e++) begin
            step();
            if (done) n_done++;
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", n_done); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL mid_hilo got %h %h want 0 0", hi, lo); end
        reset = 1'b1; step();
        reset = 1'b0; op_mult = 1'b1; rs_val = 32'd9; rt_val = 32'd9;
        step();
        op_mult = 1'b0;
        checks++; if (busy !== 1'b1 || mult_init !== 1'b1) begin errors++; $display("FAIL mid_restart got %b %b want 1 1", busy, mult_init); end
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_done_timeout got 0 want 1"); end
        checks++; if (hi !== 32'd0 || lo !== 32'd81) begin errors++; $display("FAIL mid_result got %h %h want 0 51", hi, lo); end
        step();
    endtask

    initial begin
        reset = 1'b1; op_mult = 1'b0; op_mthi = 1'b0; op_mtlo = 1'b0;
        rs_val = 32'd0; rt_val = 32'd0;
        repeat (2) step();
        reset = 1'b0;
        test_reset();
        test_mult();
        test_moves();
        test_busy_ignore();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
